lfsr_stream_gen: RTL

Registered PRBS source built on a Fibonacci LFSR: advances a parametrised polynomial by OUTPUT_WIDTH steps per word and presents each word on an AXI-Stream master port with full backpressure. Adds runtime seed loading, zero-seed protection, framing via tlast, single-bit error injection and a word counter. It feeds link/BER test paths and serves as the stimulus source for the matching checker.

---
 rtl/lfsr_stream_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/lfsr_stream_gen.sv
// Fibonacci-LFSR PRBS source on an AXI-Stream master port. Each word is OUTPUT_WIDTH
// LFSR steps with the first emitted bit in tdata[0]. State vectors put s[1] in the MSB.
module lfsr_stream_gen #(
  parameter int                      POLY_DEGREE  = 7,
  parameter logic [POLY_DEGREE:1]    POLYNOMIAL   = 7'b110_0000,
  parameter int                      OUTPUT_WIDTH = 8,
  parameter logic [POLY_DEGREE-1:0]  SEED         = '1,
  parameter int                      FRAME_LEN    = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic                      seed_load,
  input  logic [POLY_DEGREE-1:0]    seed_data,
  output logic                      seed_zero,
  input  logic                      err_inject,
  output logic [OUTPUT_WIDTH-1:0]   m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [31:0]               words_sent
);

  localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [POLY_DEGREE-1:0]  r_state;
  logic [OUTPUT_WIDTH-1:0] r_tdata;
  logic                    r_tvalid;
  logic                    r_tlast;
  logic                    r_seed_zero;
  logic                    r_inj_pend;
  logic [31:0]             r_words_sent;
  logic [FCW-1:0]          r_frame_cnt;

  logic [POLY_DEGREE-1:0]  w_tap_mask;
  logic [POLY_DEGREE-1:0]  w_seed_fixed;
  logic [POLY_DEGREE-1:0]  w_s_eff;
  logic [POLY_DEGREE-1:0]  w_state_adv;
  logic [OUTPUT_WIDTH-1:0] w_word;
  logic [FCW-1:0]          w_frame_idx;
  logic [FCW-1:0]          w_frame_nxt;
  logic                    w_load;
  logic                    w_seed_is_zero;
  logic                    w_inject;
  logic                    w_last;

  // Tap x^i multiplies s[i], which lives at vector bit POLY_DEGREE-i.
  genvar gi;
  generate
    for (gi = 1; gi <= POLY_DEGREE; gi++) begin : g_tap
      assign w_tap_mask[POLY_DEGREE-gi] = POLYNOMIAL[gi];
    end
  endgenerate

  assign w_load         = enable && (!r_tvalid || m_axis_tready);
  assign w_seed_is_zero = (seed_data == '0);
  assign w_seed_fixed   = w_seed_is_zero ? SEED : seed_data;
  assign w_s_eff        = seed_load ? w_seed_fixed : r_state;
  assign w_inject       = r_inj_pend || err_inject;

  // A reseed restarts framing so the word loaded in the same cycle is index 0.
  assign w_frame_idx = seed_load ? '0 : r_frame_cnt;
  assign w_last      = (FRAME_LEN != 0) && (w_frame_idx == FCW'(FRAME_LEN - 1));
  assign w_frame_nxt = ((FRAME_LEN == 0) || w_last) ? '0 : w_frame_idx + FCW'(1);

  // Unrolled OUTPUT_WIDTH steps: emit s[n] (bit 0), shift in feedback at s[1] (MSB).
  always_comb begin
    w_state_adv = w_s_eff;
    w_word      = '0;
    for (int b = 0; b < OUTPUT_WIDTH; b++) begin
      w_word[b]   = w_state_adv[0];
      w_state_adv = {^(w_state_adv & w_tap_mask), w_state_adv[POLY_DEGREE-1:1]};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= SEED;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_seed_zero  <= 1'b0;
      r_inj_pend   <= 1'b0;
      r_words_sent <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_seed_zero <= seed_load && w_seed_is_zero;
      if (r_tvalid && m_axis_tready) begin
        r_words_sent <= r_words_sent + 32'd1;
      end
      if (w_load) begin
        r_state     <= w_state_adv;
        r_tdata     <= w_word ^ OUTPUT_WIDTH'(w_inject);
        r_tvalid    <= 1'b1;
        r_tlast     <= w_last;
        r_frame_cnt <= w_frame_nxt;
        r_inj_pend  <= 1'b0;
      end else begin
        // Held words stay untouched; only the generator state is reseeded.
        if (seed_load) begin
          r_state     <= w_seed_fixed;
          r_frame_cnt <= '0;
        end
        if (m_axis_tready) begin
          r_tvalid <= 1'b0;
        end
        r_inj_pend <= w_inject;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign seed_zero     = r_seed_zero;
  assign words_sent    = r_words_sent;

endmodule
